// File: rtl/selen_wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY, DRAIN)
//   mst_idx_t   : index of one of the two masters
//   TO_CNT_W    : width of the watchdog stall counter
package selen_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int unsigned TO_CNT_W = 10;

endpackage

// File: rtl/selen_wb_arb_rr.sv
// Combinational two-way round-robin picker.
//   req   in  : per-master request (cyc & stb)
//   last  in  : most recently granted master
//   valid out : at least one request present
//   idx   out : master to grant; on a tie the one that is not 'last'
module selen_wb_arb_rr
  import selen_wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last,
  output logic       valid,
  output mst_idx_t   idx
);

  always_comb begin
    valid = |req;
    idx   = mst_idx_t'(req[1]);
    if (req == 2'b11) begin
      idx = ~last;
    end
  end

endmodule

// File: rtl/selen_wb_arbiter.sv
// Two-master Wishbone arbiter (master 0 = L1I refill, master 1 = L1D).
// Round-robin grant held for the whole cyc envelope of the granted master.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   m_cyc_i/stb_i/we_i  : per-master control, bit i = master i
//   m_adr_i/dat_i/sel_i : per-master address/write data/selects, master 1 in upper slice
//   m_dat_o             : slave read data broadcast to both masters
//   m_ack_o             : ack routed to the granted master
//   m_err_o             : watchdog error pulse to the granted master
//   wb_*_o              : shared bus outputs, all zero outside BUSY
//   wb_dat_i, wb_ack_i  : slave read data and ack
//
// Optional feature: define SELEN_WB_ARB_TIMEOUT_EN to enable the stall
// watchdog (TIMEOUT stalled cycles -> error pulse, bus drained).
module selen_wb_arbiter
  import selen_wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            m_cyc_i,
  input  logic [1:0]            m_stb_i,
  input  logic [1:0]            m_we_i,
  input  logic [2*AW-1:0]       m_adr_i,
  input  logic [2*DW-1:0]       m_dat_i,
  input  logic [2*(DW/8)-1:0]   m_sel_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [1:0]            m_ack_o,
  output logic [1:0]            m_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [AW-1:0]         wb_adr_o,
  output logic [DW-1:0]         wb_dat_o,
  output logic [DW/8-1:0]       wb_sel_o,
  input  logic [DW-1:0]         wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int unsigned SW = DW / 8;

  arb_state_t state, state_nxt;
  mst_idx_t   gnt, gnt_nxt;
  mst_idx_t   last, last_nxt;

  logic       rr_valid;
  mst_idx_t   rr_idx;
  logic       to_hit;

  logic [AW-1:0] adr_mux;
  logic [DW-1:0] dat_mux;
  logic [SW-1:0] sel_mux;

  selen_wb_arb_rr u_rr (
    .req   (m_cyc_i & m_stb_i),
    .last  (last),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign adr_mux = gnt ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
  assign dat_mux = gnt ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
  assign sel_mux = gnt ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];

  assign m_dat_o = wb_dat_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    m_ack_o   = '0;
    m_err_o   = '0;

    case (state)
      IDLE: begin
        if (rr_valid) begin
          state_nxt = BUSY;
          gnt_nxt   = rr_idx;
          last_nxt  = rr_idx;
        end
      end
      BUSY: begin
        wb_cyc_o     = m_cyc_i[gnt];
        wb_stb_o     = m_stb_i[gnt];
        wb_we_o      = m_we_i[gnt];
        wb_adr_o     = adr_mux;
        wb_dat_o     = dat_mux;
        wb_sel_o     = sel_mux;
        m_ack_o[gnt] = wb_ack_i;
        if (!m_cyc_i[gnt]) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          m_err_o[gnt] = 1'b1;
          state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (!m_cyc_i[gnt]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SELEN_WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;
  logic                stall;

  assign stall  = (state == BUSY) && m_stb_i[gnt] && !wb_ack_i;
  // Fires in the stalled cycle that brings the count to TIMEOUT.
  assign to_hit = stall && (to_cnt == TO_CNT_W'(TIMEOUT - 1));

  // Leaving BUSY is the only way the grant can change, so clearing
  // outside BUSY also covers the grant-change case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != BUSY || wb_ack_i) begin
      to_cnt <= '0;
    end else if (stall) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic [TO_CNT_W-1:0] to_unused;
  assign to_unused = TO_CNT_W'(TIMEOUT);
  assign to_hit    = 1'b0;
`endif

endmodule
